// File: rtl/stump_pkg.sv
// stump_pkg: shared Stump encodings for the control unit, ALU and verification model
package stump_pkg;
  typedef enum logic [1:0] {
    ST_FETCH   = 2'b00,
    ST_EXECUTE = 2'b01,
    ST_MEMORY  = 2'b10
  } state_e;
  localparam logic [2:0] OP_ADD  = 3'd0;
  localparam logic [2:0] OP_ADC  = 3'd1;
  localparam logic [2:0] OP_SUB  = 3'd2;
  localparam logic [2:0] OP_SBC  = 3'd3;
  localparam logic [2:0] OP_AND  = 3'd4;
  localparam logic [2:0] OP_OR   = 3'd5;
  localparam logic [2:0] OP_LDST = 3'd6;
  localparam logic [2:0] OP_BCC  = 3'd7;
  localparam logic [2:0] FN_ADD  = 3'd0;
  localparam logic [2:0] FN_ADC  = 3'd1;
  localparam logic [2:0] FN_SUB  = 3'd2;
  localparam logic [2:0] FN_SBC  = 3'd3;
  localparam logic [2:0] FN_AND  = 3'd4;
  localparam logic [2:0] FN_OR   = 3'd5;
  localparam logic [3:0] CC_AL = 4'd0;
  localparam logic [3:0] CC_NV = 4'd1;
  localparam logic [3:0] CC_HI = 4'd2;
  localparam logic [3:0] CC_LS = 4'd3;
  localparam logic [3:0] CC_CC = 4'd4;
  localparam logic [3:0] CC_CS = 4'd5;
  localparam logic [3:0] CC_NE = 4'd6;
  localparam logic [3:0] CC_EQ = 4'd7;
  localparam logic [3:0] CC_VC = 4'd8;
  localparam logic [3:0] CC_VS = 4'd9;
  localparam logic [3:0] CC_PL = 4'd10;
  localparam logic [3:0] CC_MI = 4'd11;
  localparam logic [3:0] CC_GE = 4'd12;
  localparam logic [3:0] CC_LT = 4'd13;
  localparam logic [3:0] CC_GT = 4'd14;
  localparam logic [3:0] CC_LE = 4'd15;
  localparam int FLAG_N = 3;
  localparam int FLAG_Z = 2;
  localparam int FLAG_V = 1;
  localparam int FLAG_C = 0;
  function automatic logic [15:0] sext8(input logic [7:0] x);
    return {{8{x[7]}}, x};
  endfunction
  function automatic logic [15:0] sext5(input logic [4:0] x);
    return {{11{x[4]}}, x};
  endfunction
endpackage

// File: rtl/stump_cond_eval.sv
// stump_cond_eval: branch condition evaluation against {N,Z,V,C}, C treated as borrow
module stump_cond_eval
  import stump_pkg::*;
(
  input  logic [3:0] cond,
  input  logic [3:0] cc,
  output logic       taken
);
  logic n, z, v, c;
  logic [15:0] tbl;
  assign n = cc[FLAG_N];
  assign z = cc[FLAG_Z];
  assign v = cc[FLAG_V];
  assign c = cc[FLAG_C];
  // Evaluate every condition in parallel and select the requested one
  always_comb begin
    tbl        = '0;
    tbl[CC_AL] = 1'b1;
    tbl[CC_NV] = 1'b0;
    tbl[CC_HI] = !c && !z;
    tbl[CC_LS] = c || z;
    tbl[CC_CC] = !c;
    tbl[CC_CS] = c;
    tbl[CC_NE] = !z;
    tbl[CC_EQ] = z;
    tbl[CC_VC] = !v;
    tbl[CC_VS] = v;
    tbl[CC_PL] = !n;
    tbl[CC_MI] = n;
    tbl[CC_GE] = n == v;
    tbl[CC_LT] = n != v;
    tbl[CC_GT] = !z && (n == v);
    tbl[CC_LE] = z || (n != v);
    taken      = tbl[cond];
  end
endmodule

// File: rtl/stump_control.sv
// stump_control: Stump multi-cycle control unit (IR, condition codes, FETCH/EXECUTE/MEMORY sequencing)
module stump_control
  import stump_pkg::*;
(
  input  logic        clk,
  input  logic        rst_n,
  input  logic [15:0] mem_rdata,
  input  logic        mem_ack,
  input  logic [3:0]  flags_in,
  output logic [1:0]  state,
  output logic [15:0] ir,
  output logic [2:0]  func,
  output logic        c_out,
  output logic [2:0]  src_a,
  output logic [2:0]  src_b,
  output logic [2:0]  dest,
  output logic [1:0]  shift_op,
  output logic        opb_imm,
  output logic [15:0] imm16,
  output logic        addr_sel,
  output logic        mem_req,
  output logic        mem_wen,
  output logic        reg_wen,
  output logic        pc_inc,
  output logic [3:0]  cc
);
  state_e      state_q, state_d;
  logic [15:0] ir_q, ir_d;
  logic [3:0]  cc_q, cc_d;
  logic [2:0]  op;
  logic        is_alu, is_ldst, is_bcc, taken;
  assign op      = ir_q[15:13];
  assign is_ldst = op == OP_LDST;
  assign is_bcc  = op == OP_BCC;
  assign is_alu  = !is_ldst && !is_bcc;
  stump_cond_eval u_cond (
    .cond  (ir_q[11:8]),
    .cc    (cc_q),
    .taken (taken)
  );
  // State, instruction and condition-code registers; reset abandons any instruction in flight
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_FETCH;
      ir_q    <= '0;
      cc_q    <= '0;
    end else begin
      state_q <= state_d;
      ir_q    <= ir_d;
      cc_q    <= cc_d;
    end
  end
  // Sequencing: latch the instruction on fetch ack, update flags on S-bit ALU ops
  always_comb begin
    state_d = state_q;
    ir_d    = ir_q;
    cc_d    = cc_q;
    case (state_q)
      ST_FETCH: begin
        if (mem_ack) begin
          ir_d    = mem_rdata;
          state_d = ST_EXECUTE;
        end
      end
      ST_EXECUTE: begin
        state_d = is_ldst ? ST_MEMORY : ST_FETCH;
        if (is_alu && ir_q[11]) cc_d = flags_in;
      end
      ST_MEMORY: state_d = mem_ack ? ST_FETCH : ST_MEMORY;
      default:   state_d = ST_FETCH;
    endcase
  end
  // Decode and strobes; branches reuse the adder as PC + sext(offset) into r7
  always_comb begin
    state    = state_q;
    ir       = ir_q;
    cc       = cc_q;
    c_out    = cc_q[FLAG_C];
    func     = is_alu ? op : FN_ADD;
    src_a    = is_bcc ? 3'd7 : ir_q[7:5];
    src_b    = ir_q[4:2];
    dest     = is_bcc ? 3'd7 : ir_q[10:8];
    opb_imm  = is_bcc || ir_q[12];
    shift_op = opb_imm ? 2'b00 : ir_q[1:0];
    imm16    = is_bcc ? sext8(ir_q[7:0]) : sext5(ir_q[4:0]);
    addr_sel = state_q == ST_MEMORY;
    mem_req  = state_q == ST_FETCH || state_q == ST_MEMORY;
    mem_wen  = addr_sel && ir_q[11];
    pc_inc   = rst_n && state_q == ST_FETCH && mem_ack;
    reg_wen  = (state_q == ST_EXECUTE && (is_alu || (is_bcc && taken)))
            || (state_q == ST_MEMORY && mem_ack && !ir_q[11]);
  end
endmodule
